// File: rtl/instr_fetch_pkg.sv
// Shared constants and fetch-state encoding for the 16-bit core front end.
package instr_fetch_pkg;

  localparam logic [15:0] NOP_WORD    = 16'h0020;
  localparam logic [3:0]  OP_BCOND    = 4'b1100;
  localparam logic [3:0]  OP_JCOND_HI = 4'b0100;
  localparam logic [3:0]  OP_JCOND_LO = 4'b1100;
  localparam logic [3:0]  COND_NEVER  = 4'b1111;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    ISSUE = 2'd2
  } fetch_state_e;

  function automatic logic [15:0] sext8(input logic [7:0] v);
    return {{8{v[7]}}, v};
  endfunction

endpackage

// File: rtl/instr_fetch_next_pc_calc.sv
// Next-PC selection for a retiring instruction: sequential, PC-relative branch or register jump.
module next_pc_calc
  import instr_fetch_pkg::*;
(
  input  logic [15:0] pc,
  input  logic [15:0] decoded,
  input  logic [15:0] jump_target,
  output logic [15:0] next_pc,
  output logic        redirect
);

  logic branch_taken;
  logic jump_taken;

  // A failed condition arrives here already turned into a NOP, so only the
  // "never" condition code has to be filtered out of the branch form.
  assign branch_taken = (decoded[15:12] == OP_BCOND) && (decoded[11:8] != COND_NEVER);
  assign jump_taken   = (decoded[15:12] == OP_JCOND_HI) && (decoded[7:4] == OP_JCOND_LO);
  assign redirect     = branch_taken | jump_taken;

  always_comb begin
    next_pc = pc + 16'd1;
    if (branch_taken) begin
      next_pc = pc + sext8(decoded[7:0]);
    end else if (jump_taken) begin
      next_pc = jump_target;
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: PC sequencing and req/ack instruction memory fetch.
// Optional one-word prefetch buffer enabled by defining INSTR_FETCH_PREFETCH_EN.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] NOP_WORD = instr_fetch_pkg::NOP_WORD
) (
  input  logic        clock,
  input  logic        reset,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  input  logic        mem_ack,
  input  logic [15:0] mem_rdata,
  output logic [15:0] instr,
  output logic        instr_valid,
  input  logic        stall,
  input  logic [15:0] decoded,
  output logic [3:0]  jump_reg,
  input  logic [15:0] jump_target,
  output logic [15:0] pc
);

  fetch_state_e state, state_d;
  logic [15:0]  fetch_addr, fetch_addr_d;
  logic [15:0]  pc_d, instr_d;
  logic         valid_d;
  logic         req;
  logic [15:0]  next_pc;
  logic         redirect;

`ifdef INSTR_FETCH_PREFETCH_EN
  logic        pf_valid, pf_valid_d;
  logic [15:0] pf_word, pf_word_d;
  logic        drop, drop_d;
  logic [15:0] pc_inc;

  assign pc_inc = pc + 16'd1;
`endif

  assign jump_reg = decoded[3:0];
  assign mem_req  = req & ~reset;

  next_pc_calc u_next_pc_calc (
    .pc          (pc),
    .decoded     (decoded),
    .jump_target (jump_target),
    .next_pc     (next_pc),
    .redirect    (redirect)
  );

  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves a latch.
    state_d      = state;
    fetch_addr_d = fetch_addr;
    pc_d         = pc;
    instr_d      = instr;
    valid_d      = instr_valid;
    req          = 1'b0;
    mem_addr     = fetch_addr;
`ifdef INSTR_FETCH_PREFETCH_EN
    pf_valid_d   = pf_valid;
    pf_word_d    = pf_word;
    drop_d       = drop;
`endif
    unique case (state)
      FETCH: begin
        req     = 1'b1;
        state_d = WAIT;
      end
      WAIT: begin
        req = 1'b1;
`ifdef INSTR_FETCH_PREFETCH_EN
        // A redirected prefetch keeps its original address until it completes.
        if (drop) mem_addr = pc_inc;
        if (mem_ack && drop) begin
          drop_d  = 1'b0;
          state_d = FETCH;
        end else if (mem_ack) begin
`else
        if (mem_ack) begin
`endif
          instr_d = mem_rdata;
          valid_d = 1'b1;
          pc_d    = fetch_addr;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
`ifdef INSTR_FETCH_PREFETCH_EN
        req      = ~pf_valid;
        mem_addr = pc_inc;
        if (req && mem_ack) begin
          pf_valid_d = 1'b1;
          pf_word_d  = mem_rdata;
        end
        if (!stall) begin
          fetch_addr_d = next_pc;
          pf_valid_d   = 1'b0;
          instr_d      = NOP_WORD;
          valid_d      = 1'b0;
          state_d      = FETCH;
          if (redirect) begin
            if (req && !mem_ack) begin
              drop_d  = 1'b1;
              state_d = WAIT;
            end
          end else if (pf_valid || mem_ack) begin
            instr_d = pf_valid ? pf_word : mem_rdata;
            valid_d = 1'b1;
            pc_d    = next_pc;
            state_d = ISSUE;
          end else begin
            // The pending prefetch already targets the sequential address.
            state_d = WAIT;
          end
        end
`else
        if (!stall) begin
          fetch_addr_d = next_pc;
          instr_d      = NOP_WORD;
          valid_d      = 1'b0;
          state_d      = FETCH;
        end
`endif
      end
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clock) begin
    // NOTE: registers are updated with non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      state       <= FETCH;
      fetch_addr  <= RESET_PC;
      pc          <= RESET_PC;
      instr       <= NOP_WORD;
      instr_valid <= 1'b0;
`ifdef INSTR_FETCH_PREFETCH_EN
      pf_valid    <= 1'b0;
      pf_word     <= NOP_WORD;
      drop        <= 1'b0;
`endif
    end else begin
      state       <= state_d;
      fetch_addr  <= fetch_addr_d;
      pc          <= pc_d;
      instr       <= instr_d;
      instr_valid <= valid_d;
`ifdef INSTR_FETCH_PREFETCH_EN
      pf_valid    <= pf_valid_d;
      pf_word     <= pf_word_d;
      drop        <= drop_d;
`endif
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed self-checking bench for instr_fetch with hand-computed expected fetch addresses.
module tb_instr_fetch;
  import instr_fetch_pkg::*;

  localparam logic [15:0] RST_PC = 16'h0010;

  logic        clock = 1'b0;
  logic        reset;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic [15:0] instr;
  logic        instr_valid;
  logic        stall;
  logic [15:0] decoded;
  logic [3:0]  jump_reg;
  logic [15:0] jump_target;
  logic [15:0] pc;

  int total = 0;
  int bad   = 0;

  instr_fetch #(.RESET_PC(RST_PC), .NOP_WORD(NOP_WORD)) dut (
    .clock       (clock),
    .reset       (reset),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .instr       (instr),
    .instr_valid (instr_valid),
    .stall       (stall),
    .decoded     (decoded),
    .jump_reg    (jump_reg),
    .jump_target (jump_target),
    .pc          (pc)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  // Waits for a request, checks its address, then acks after 'delay' WAIT cycles.
  task automatic serve(input logic [15:0] word, input int delay, input logic [15:0] exp_addr,
                       input string tag);
    int n = 0;
    while (mem_req !== 1'b1 && n < 20) begin
      tick;
      n++;
    end
    check({tag, " req"}, {15'd0, mem_req}, 16'd1);
    check({tag, " addr"}, mem_addr, exp_addr);
    if (mem_req === 1'b1) begin
      tick;
      for (int i = 0; i < delay; i++) begin
        check({tag, " hold"}, mem_addr, exp_addr);
        tick;
      end
      mem_ack   = 1'b1;
      mem_rdata = word;
      tick;
      mem_ack   = 1'b0;
      mem_rdata = 16'h0000;
      #1;
      check({tag, " instr"}, instr, word);
      check({tag, " valid"}, {15'd0, instr_valid}, 16'd1);
      check({tag, " pc"}, pc, exp_addr);
      check({tag, " issue_req"}, {15'd0, mem_req}, 16'd0);
    end
  endtask

  // Retires the instruction in ISSUE and checks the redirect request that follows.
  task automatic retire(input logic [15:0] dec, input logic [15:0] jt, input logic [15:0] exp_addr,
                        input string tag);
    decoded     = dec;
    jump_target = jt;
    stall       = 1'b0;
    tick;
    decoded = NOP_WORD;
    #1;
    check({tag, " valid"}, {15'd0, instr_valid}, 16'd0);
    check({tag, " instr"}, instr, NOP_WORD);
    check({tag, " req"}, {15'd0, mem_req}, 16'd1);
    check({tag, " next_addr"}, mem_addr, exp_addr);
  endtask

  initial begin
    reset       = 1'b1;
    stall       = 1'b0;
    mem_ack     = 1'b0;
    mem_rdata   = 16'h0000;
    decoded     = NOP_WORD;
    jump_target = 16'h0000;
    repeat (2) tick;
    check("rst mem_req", {15'd0, mem_req}, 16'd0);
    check("rst instr", instr, NOP_WORD);
    check("rst valid", {15'd0, instr_valid}, 16'd0);
    check("rst pc", pc, RST_PC);
    check("rst mem_addr", mem_addr, RST_PC);
    reset = 1'b0;
    #1;

`ifndef INSTR_FETCH_PREFETCH_EN
    serve(16'h1234, 0, 16'h0010, "first");
    retire(NOP_WORD, 16'h0000, 16'h0011, "seq");
    serve(NOP_WORD, 0, 16'h0011, "nop_word");
    retire(16'hC00F, 16'h0000, 16'h0020, "br_fwd");
    serve(16'hAAAA, 0, 16'h0020, "at_0020");
    retire(16'hC0FE, 16'h0000, 16'h001E, "br_back");
    serve(16'hBBBB, 0, 16'h001E, "at_001e");
    retire(16'hC012, 16'h0000, 16'h0030, "br_to_0030");
    serve(16'hCCCC, 0, 16'h0030, "at_0030");
    decoded     = 16'h40C5;
    jump_target = 16'h0200;
    #1;
    check("jump_reg", {12'd0, jump_reg}, 16'd5);
    retire(16'h40C5, 16'h0200, 16'h0200, "jump");
    serve(16'hDDDD, 0, 16'h0200, "at_0200");
    retire(16'h40C3, 16'hFFFF, 16'hFFFF, "jump_ffff");
    serve(16'hEEEE, 0, 16'hFFFF, "at_ffff");

    // Stall in ISSUE with a stray ack that must be ignored.
    stall     = 1'b1;
    mem_ack   = 1'b1;
    mem_rdata = 16'hDEAD;
    for (int i = 0; i < 3; i++) begin
      tick;
      check("stall instr", instr, 16'hEEEE);
      check("stall pc", pc, 16'hFFFF);
      check("stall req", {15'd0, mem_req}, 16'd0);
      check("stall valid", {15'd0, instr_valid}, 16'd1);
    end
    mem_ack   = 1'b0;
    mem_rdata = 16'h0000;

    retire(NOP_WORD, 16'h0000, 16'h0000, "pc_wrap");
    serve(16'h1111, 0, 16'h0000, "at_0000");
    retire(16'hCF05, 16'h0000, 16'h0001, "cond_never");
    serve(16'h2222, 4, 16'h0001, "slow_ack");
    retire(NOP_WORD, 16'h0000, 16'h0002, "seq2");

    // Reset in WAIT, then a late ack for the aborted request.
    tick;
    check("mid_wait req", {15'd0, mem_req}, 16'd1);
    reset = 1'b1;
    #1;
    check("rst req drop", {15'd0, mem_req}, 16'd0);
    tick;
    check("rst2 valid", {15'd0, instr_valid}, 16'd0);
    check("rst2 instr", instr, NOP_WORD);
    check("rst2 pc", pc, RST_PC);
    check("rst2 mem_addr", mem_addr, RST_PC);
    reset     = 1'b0;
    mem_ack   = 1'b1;
    mem_rdata = 16'hBAD1;
    tick;
    mem_ack   = 1'b0;
    mem_rdata = 16'h0000;
    check("late_ack valid", {15'd0, instr_valid}, 16'd0);
    check("late_ack instr", instr, NOP_WORD);
    serve(16'h3333, 0, 16'h0010, "recover");
`else
    check("pf req0", {15'd0, mem_req}, 16'd1);
    check("pf addr0", mem_addr, 16'h0010);
    tick;
    mem_ack   = 1'b1;
    mem_rdata = 16'h1234;
    tick;
    #1;
    check("pf instr0", instr, 16'h1234);
    check("pf pc0", pc, 16'h0010);
    check("pf prefetch addr", mem_addr, 16'h0011);
    stall     = 1'b1;
    mem_rdata = 16'h5555;
    tick;
    mem_ack = 1'b0;
    #1;
    check("pf buffer full req", {15'd0, mem_req}, 16'd0);
    check("pf stall instr", instr, 16'h1234);
    stall   = 1'b0;
    decoded = 16'hC005;
    tick;
    decoded = NOP_WORD;
    #1;
    check("pf br valid", {15'd0, instr_valid}, 16'd0);
    check("pf br addr", mem_addr, 16'h0015);
    tick;
    mem_ack   = 1'b1;
    mem_rdata = 16'h7777;
    tick;
    mem_ack = 1'b0;
    #1;
    check("pf discard instr", instr, 16'h7777);
    check("pf discard pc", pc, 16'h0015);
    check("pf next addr", mem_addr, 16'h0016);
    mem_ack   = 1'b1;
    mem_rdata = 16'h8888;
    tick;
    mem_ack = 1'b0;
    #1;
    check("pf b2b instr", instr, 16'h8888);
    check("pf b2b pc", pc, 16'h0016);
    check("pf b2b valid", {15'd0, instr_valid}, 16'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch unit for the 16-bit core. It drives the program counter and fetches one word per instruction from instruction memory over a req/ack handshake. It presents each fetched word to the condition/branch decoder and consumes the decoder's resolved output to select the next PC: sequential, PC-relative branch, or register jump.

## Interface
- `RESET_PC`, default 16'h0000: PC loaded on reset.
- `NOP_WORD`, default 16'h0020: instruction word presented while no valid fetch is held.
- `clock` in 1: single clock domain, rising edge.
- `reset` in 1: synchronous, active-high.
- `mem_req` out 1: instruction memory read request.
- `mem_addr` out 16: word address of the request.
- `mem_ack` in 1: read complete; `mem_rdata` is valid in the same cycle.
- `mem_rdata` in 16: fetched instruction word.
- `instr` out 16: instruction word to the decoder.
- `instr_valid` out 1: `instr` is a real fetched word.
- `stall` in 1: downstream cannot accept; hold the current instruction.
- `decoded` in 16: decoder output for the current `instr`; already NOP if the condition failed.
- `jump_reg` out 4: register index to read for a jump, equal to `decoded[3:0]`.
- `jump_target` in 16: register-file value of `jump_reg`, combinational.
- `pc` out 16: address of the instruction currently in `instr`.

## Operation
- States: FETCH, WAIT, ISSUE.
- FETCH: assert `mem_req`, with `mem_addr` = next-fetch address. Go to WAIT.
- WAIT: keep `mem_req` and `mem_addr` stable until `mem_ack`. On ack, capture `mem_rdata` into `instr`, set `instr_valid`=1, set `pc` = fetch address, go to ISSUE.
- ISSUE with `stall`=1: hold `instr`, `pc` and `instr_valid`. Issue no request.
- ISSUE with `stall`=0: the instruction retires this cycle. Compute the next PC from `decoded`:
  - `decoded[15:12]`==4'b1100 and `decoded[11:8]`!=4'b1111: branch taken. next = `pc` + sign-extended `decoded[7:0]`, modulo 2^16.
  - `{decoded[15:12],decoded[7:4]}`==8'b01001100: jump taken. next = `jump_target`.
  - Otherwise, including NOP_WORD: next = `pc`+1, modulo 2^16.
  - Then clear `instr_valid`, drive `instr`=NOP_WORD, and go to FETCH.
- PC wrap: 16'hFFFF+1 gives 16'h0000. A branch displacement that wraps also wraps silently.
- Reset has priority over everything, including mid-WAIT. `mem_req` drops in the reset cycle, and any late `mem_ack` for the aborted request is ignored.
- A `mem_ack` outside WAIT is ignored.

## Timing
- Reset values:
  - `pc`=RESET_PC, next-fetch address=RESET_PC.
  - `instr`=NOP_WORD, `instr_valid`=0, `mem_req`=0, `mem_addr`=RESET_PC, state FETCH.
- First `mem_req` is asserted in the cycle after reset deasserts.
- Non-prefetch throughput with zero-wait memory: FETCH→WAIT (ack)→ISSUE, so 3 cycles per instruction.
- Redirect-to-request latency: the next `mem_req` follows in the cycle after ISSUE retires.
- `decoded` and `jump_target` are sampled only on the ISSUE clock edge with `stall`=0.

## Configuration
- `INSTR_FETCH_PREFETCH_EN` defined:
  - A one-word prefetch buffer is added. While in ISSUE, the unit requests `pc`+1.
  - On retire with a sequential next PC, a held prefetch word (or an ack in the same cycle) moves into `instr` the next cycle, bypassing FETCH/WAIT. Throughput is 1 instruction per cycle with zero-wait memory.
  - On a taken branch or jump, the prefetch word is discarded. An outstanding request is allowed to complete and its data is dropped.
- Not defined: no buffer, and behaviour is exactly as in Operation.

## Structure
- Shared core package holds:
  - `NOP_WORD` constant, `OP_BCOND`=4'b1100, `OP_JCOND_HI`=4'b0100, `OP_JCOND_LO`=4'b1100, `COND_NEVER`=4'b1111.
  - Fetch state enum.
- One sub-module, `next_pc_calc`: combinational next-PC selection from `pc`, `decoded` and `jump_target`.

## Test plan
- Reset with RESET_PC=16'h0010, memory returns 16'h1234 at 0x10 and NOP_WORD at 0x11 -> first `mem_addr`=0x10; `instr`=16'h1234 with `instr_valid`=1, `pc`=0x10; next request goes to 0x11.
- `pc`=0x0020, `decoded`=16'hC0FE (branch, disp −2) -> next `mem_addr`=0x001E.
- `pc`=0x0030, `decoded`=16'h40C5, `jump_target`=16'h0200 -> `jump_reg`=5, next `mem_addr`=0x0200.
- `pc`=16'hFFFF with `decoded`=NOP_WORD -> next `mem_addr`=0x0000. `decoded`=16'hCF05 (never) -> sequential.
- `stall` held 3 cycles in ISSUE -> `instr` and `pc` stable, no `mem_req`. `mem_ack` delayed 4 cycles in WAIT -> `mem_addr` stable throughout.
- Reset asserted mid-WAIT, then a late `mem_ack` arrives -> state FETCH, `instr_valid`=0, late data not captured. With prefetch on, a taken branch discards the buffered word.
